// File: rtl/button_events_pkg.sv
// Shared types and helpers for button_events: FSM state encoding and hold-counter sizing.
package button_events_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPressed = 2'd1,
    StLong    = 2'd2
  } state_e;

  // Width needed to count up to the larger of the two terminal values.
  function automatic int unsigned cnt_width(int unsigned long_cycles,
                                            int unsigned repeat_cycles);
    int unsigned max_cycles;
    max_cycles = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
    if (max_cycles < 2) begin
      return 1;
    end
    return $clog2(max_cycles);
  endfunction

endpackage

// File: rtl/button_events_hold_timer.sv
// Hold-duration counter for button_events; flags when the count equals the supplied terminal.
module hold_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] terminal,
  output logic             done
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == terminal);

endmodule

// File: rtl/button_events.sv
// Turns a debounced button level into one-cycle press/release/click/long-press events.
// Optional auto-repeat pulses are built when BTN_REPEAT_EN is defined.
module button_events
  import button_events_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 12_000_000,
  parameter int unsigned REPEAT_CYCLES = 2_400_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press,
  output logic release_pulse,
  output logic click,
  output logic long_press,
`ifdef BTN_REPEAT_EN
  output logic repeat_pulse,
`endif
  output logic held
);

  localparam int unsigned CntW = cnt_width(LONG_CYCLES, REPEAT_CYCLES);

  state_e state_q, state_d;

  logic            done, clear, enable;
  logic [CntW-1:0] terminal;

  logic press_d, release_d, click_d, long_d, held_d;
  logic press_q, release_q, click_q, long_q, held_q;
`ifdef BTN_REPEAT_EN
  logic repeat_d, repeat_q;
`endif

  // Single timer shared by both hold phases; the compare value follows the state.
  assign terminal = (state_q == StLong) ? CntW'(REPEAT_CYCLES - 1) : CntW'(LONG_CYCLES - 1);

  hold_timer #(
    .Width(CntW)
  ) u_hold_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .enable  (enable),
    .terminal(terminal),
    .done    (done)
  );

  // Release is tested before terminal count so it wins on a coincident edge.
  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
`ifdef BTN_REPEAT_EN
    repeat_d  = 1'b0;
`endif
    clear     = 1'b1;
    enable    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (btn) begin
          state_d = StPressed;
          press_d = 1'b1;
        end
      end
      StPressed: begin
        if (!btn) begin
          state_d   = StIdle;
          release_d = 1'b1;
          click_d   = 1'b1;
        end else if (done) begin
          state_d = StLong;
          long_d  = 1'b1;
        end else begin
          clear  = 1'b0;
          enable = 1'b1;
        end
      end
      StLong: begin
        if (!btn) begin
          state_d   = StIdle;
          release_d = 1'b1;
        end
`ifdef BTN_REPEAT_EN
        else if (done) begin
          repeat_d = 1'b1;
        end else begin
          clear  = 1'b0;
          enable = 1'b1;
        end
`endif
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    held_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
`ifdef BTN_REPEAT_EN
      repeat_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      long_q    <= long_d;
      held_q    <= held_d;
`ifdef BTN_REPEAT_EN
      repeat_q  <= repeat_d;
`endif
    end
  end

  assign press         = press_q;
  assign release_pulse = release_q;
  assign click         = click_q;
  assign long_press    = long_q;
  assign held          = held_q;
`ifdef BTN_REPEAT_EN
  assign repeat_pulse  = repeat_q;
`endif

endmodule

// File: tb/tb_button_events.sv
// Self-checking bench for button_events: directed scenarios plus random hold lengths,
// compared against a hold-age model of the event rules.
module tb_button_events;

  localparam int unsigned L = 8;
  localparam int unsigned R = 4;
`ifdef BTN_REPEAT_EN
  localparam bit RepEn = 1'b1;
`else
  localparam bit RepEn = 1'b0;
`endif

  logic clk, rst_n, btn;
  logic press, release_pulse, click, long_press, held;
  logic repeat_pulse;

  int n_vec = 0;
  int n_err = 0;

  // Model: whether a hold is in progress and how many edges since the press edge.
  bit m_pr  = 1'b0;
  int m_age = 0;

  button_events #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .press        (press),
    .release_pulse(release_pulse),
    .click        (click),
    .long_press   (long_press),
`ifdef BTN_REPEAT_EN
    .repeat_pulse (repeat_pulse),
`endif
    .held         (held)
  );

`ifndef BTN_REPEAT_EN
  assign repeat_pulse = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input logic e_press, input logic e_rel, input logic e_click,
                           input logic e_long, input logic e_rep, input logic e_held);
    check("press", press, e_press);
    check("release_pulse", release_pulse, e_rel);
    check("click", click, e_click);
    check("long_press", long_press, e_long);
    check("repeat_pulse", repeat_pulse, e_rep);
    check("held", held, e_held);
  endtask

  // Drive one btn level, clock once, advance the model and compare all outputs.
  task automatic step(input logic b);
    logic e_press, e_rel, e_click, e_long, e_rep;
    e_press = 1'b0; e_rel = 1'b0; e_click = 1'b0; e_long = 1'b0; e_rep = 1'b0;
    btn = b;
    @(posedge clk);
    if (!m_pr) begin
      if (b) begin
        m_pr    = 1'b1;
        m_age   = 0;
        e_press = 1'b1;
      end
    end else begin
      m_age++;
      if (!b) begin
        e_rel   = 1'b1;
        e_click = (m_age <= int'(L));
        m_pr    = 1'b0;
      end else begin
        e_long = (m_age == int'(L));
        e_rep  = RepEn && (m_age > int'(L)) && (((m_age - int'(L)) % int'(R)) == 0);
      end
    end
    #1;
    check_all(e_press, e_rel, e_click, e_long, e_rep, m_pr);
  endtask

  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 1'b0;
    #12;
    check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    run(1'b0, 2);

    // Short press
    run(1'b1, 3);
    run(1'b0, 3);

    // Long hold, repeats when enabled
    run(1'b1, 18);
    run(1'b0, 3);

    // Release coincident with long-press terminal count
    run(1'b1, 8);
    run(1'b0, 3);

    // Long hold, exactly one long_press
    run(1'b1, 30);
    run(1'b0, 2);

    // Asynchronous reset in the middle of a long hold
    run(1'b1, 11);
    #3 rst_n = 1'b0;
    #1;
    check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_pr = 1'b0;
    repeat (2) @(posedge clk);
    #1 btn = 1'b1;
    #2 rst_n = 1'b1;
    run(1'b1, 12);
    run(1'b0, 2);

    // Random hold and gap lengths spanning the terminal counts
    for (int k = 0; k < 60; k++) begin
      run(1'b1, int'($urandom_range(1, 22)));
      run(1'b0, int'($urandom_range(1, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_events.md
# button_events

Converts the clean level from the push-button debouncer into single-cycle user events: press, release, click, long-press and optional auto-repeat. Sits between the debouncer and the display/mode control logic, so that consumers never do their own edge detection or hold timing. All outputs are registered, and every pulse is exactly one clock wide.

## Interface
- `LONG_CYCLES`, default 12_000_000: cycles the button must be held before `long_press` fires. Default is 1 s at 12 MHz. Must be ≥ 2.
- `REPEAT_CYCLES`, default 2_400_000: interval between `repeat_pulse` events once long-press is reached. Default is 200 ms. Must be ≥ 2.
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn` in 1: debounced button level, synchronous to `clk`; 1 = pressed.
- `press` out 1: one-cycle pulse on a press.
- `release_pulse` out 1: one-cycle pulse on any release.
- `click` out 1: one-cycle pulse on a release that happens before long-press; coincides with `release_pulse`.
- `long_press` out 1: one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeat_pulse` out 1: one-cycle pulse every `REPEAT_CYCLES` after long-press. Only exists with `BTN_REPEAT_EN`.
- `held` out 1: level, 1 whenever the FSM is not in IDLE.

## Operation
- Counter `cnt` is `CNT_W` = $clog2(max(LONG_CYCLES, REPEAT_CYCLES)) bits wide and unsigned. It is cleared on every state change and never wraps, because it is cleared at each terminal count.
- The FSM has three states: IDLE, PRESSED, LONG.
- **IDLE**, `btn`=1: go to PRESSED, assert `press`, set `cnt` to 0.
- **PRESSED**, `btn`=0: go to IDLE, assert `release_pulse` and `click`.
- **PRESSED**, `btn`=1 and `cnt`==LONG_CYCLES-1: go to LONG, assert `long_press`, set `cnt` to 0.
- **PRESSED**, `btn`=1 otherwise: increment `cnt`.
- **LONG**, `btn`=0: go to IDLE, assert `release_pulse` only (no `click`).
- **LONG**, `btn`=1 and `cnt`==REPEAT_CYCLES-1: assert `repeat_pulse`, set `cnt` to 0, stay in LONG. This only applies with `BTN_REPEAT_EN`.
- **LONG**, `btn`=1 otherwise: increment `cnt`. Without `BTN_REPEAT_EN`, `cnt` holds at 0 instead.
- Simultaneous events: if release happens on the same edge as a terminal count, release wins. No `long_press` or `repeat_pulse` is produced on that edge.
- The edge detector is the state register itself; there is no separate previous-sample flop.

## Timing
- All outputs are 0 in reset: state is IDLE and `cnt` is 0. Reset takes effect immediately and asynchronously, including in the middle of a hold.
- If `btn` is already 1 when `rst_n` deasserts, `press` fires on the first clock edge.
- Latency is one clock. Define edge N as the first edge that samples `btn`=1: `press` is high for the cycle following edge N.
- `long_press` is high after edge N+LONG_CYCLES.
- Repeats are high after edges N+LONG_CYCLES+k·REPEAT_CYCLES, for k ≥ 1.
- If edge M is the first edge that samples `btn`=0, `release_pulse` (and `click` where applicable) is high after edge M.
- `held` rises with `press` and falls with `release_pulse`.

## Configuration
- `BTN_REPEAT_EN` defined: the `repeat_pulse` port and the repeat counting in LONG are present.
- `BTN_REPEAT_EN` undefined: the `repeat_pulse` port is absent. LONG only waits for release, and `cnt` is frozen at 0 in LONG.

## Structure
- Package `button_events_pkg` holds two items:
  - the state encoding constants (IDLE/PRESSED/LONG, 2 bits);
  - the function returning the counter width from the two parameters.
- One sub-module, `hold_timer`, is natural. It has ports `clear`, `enable`, `terminal` and a compare value, and returns `done`. It is instantiated once; the compare value is muxed by state.

## Test plan
All scenarios use LONG_CYCLES=8 and REPEAT_CYCLES=4.
- Short press: `btn` high for edges 0–2, low at edge 3. Expect `press` after edge 0, `release_pulse` and `click` after edge 3, and no `long_press`.
- Hold with repeat (`BTN_REPEAT_EN`): `btn` high for edges 0–17, low at 18. Expect `press` after edge 0, `long_press` after 8, `repeat_pulse` after 12 and 16, and `release_pulse` without `click` after 18.
- Coincident release: `btn` high for edges 0–7, low at 8. Expect `release_pulse` and `click` after 8, and no `long_press` ever.
- Reset mid-hold: pull `rst_n` low while in LONG. All outputs go to 0 immediately. Release reset with `btn`=1 and expect `press` after the first edge.
- No repeat (`BTN_REPEAT_EN` undefined): hold for 30 cycles. Expect exactly one `long_press` and `held`=1 throughout.
- Pulse width check: assertions across random `btn` stimulus confirm every pulse output is exactly one cycle wide, `press` and `release_pulse` strictly alternate, and `held` matches state != IDLE.
